// File: rtl/pmod_cls_update_scheduler.sv
// Sequences clear / line1 / line2 commands to the PmodCLS driver from pulsed requests,
// with a ready handshake per command, a saturating driver timeout and a sticky error flag.
module pmod_cls_update_scheduler #(
  parameter int parm_fast_simulation = 0,
  parameter int parm_timeout_ce      = 2500000
) (
  input  logic         i_clk_20mhz,
  input  logic         i_rstn_20mhz,
  input  logic         i_ce_2_5mhz,
  input  logic         i_update_req,
  input  logic         i_clear_req,
  input  logic [127:0] i_line1,
  input  logic [127:0] i_line2,
  input  logic         i_command_ready,
  output logic         o_cmd_wr_clear_display,
  output logic         o_cmd_wr_text_line1,
  output logic         o_cmd_wr_text_line2,
  output logic [127:0] o_dat_ascii_line1,
  output logic [127:0] o_dat_ascii_line2,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_RDY, S_NEXT} state_t;
  typedef enum logic [1:0] {CLR, L1, L2} step_t;

  localparam logic [22:0]  TIMEOUT_LIMIT = (parm_fast_simulation != 0) ? 23'd1000 : 23'(parm_timeout_ce);
  localparam logic [127:0] BLANK_LINE    = {16{8'h20}};

  // Reset asserts immediately but releases only after two clean clock edges.
  logic rst_meta_q, rst_sync_q;

  always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
    if (!i_rstn_20mhz) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  state_t       state_q, state_d;
  step_t        step_q, step_d;
  logic         seq_upd_q, seq_upd_d, seq_clr_q, seq_clr_d;
  logic         pend_upd_q, pend_upd_d, pend_clr_q, pend_clr_d;
  logic [127:0] shadow1_q, shadow1_d, shadow2_q, shadow2_d;
  logic [127:0] dat1_q, dat1_d, dat2_q, dat2_d;
  logic         cmd_clr_q, cmd_clr_d, cmd_l1_q, cmd_l1_d, cmd_l2_q, cmd_l2_d;
  logic         busy_q, busy_d, done_q, done_d, tmo_err_q, tmo_err_d;
  logic [22:0]  tmo_cnt_q, tmo_cnt_d, tmo_inc;
  logic         timeout;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    seq_upd_d  = seq_upd_q;
    seq_clr_d  = seq_clr_q;
    pend_upd_d = pend_upd_q | i_update_req;
    pend_clr_d = pend_clr_q | i_clear_req;
    shadow1_d  = shadow1_q;
    shadow2_d  = shadow2_q;
    dat1_d     = dat1_q;
    dat2_d     = dat2_q;
    cmd_clr_d  = cmd_clr_q;
    cmd_l1_d   = cmd_l1_q;
    cmd_l2_d   = cmd_l2_q;
    done_d     = 1'b0;
    tmo_err_d  = tmo_err_q;
    tmo_cnt_d  = tmo_cnt_q;
    tmo_inc    = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + 23'd1;
    timeout    = 1'b0;

    if (i_update_req) begin
      shadow1_d = i_line1;
      shadow2_d = i_line2;
    end

    if (i_ce_2_5mhz) begin
      case (state_q)
        S_IDLE: begin
          if ((pend_upd_q || pend_clr_q) && i_command_ready) begin
            seq_upd_d  = pend_upd_q;
            seq_clr_d  = pend_clr_q;
            // A request landing in this very clock is kept for the next sequence.
            pend_upd_d = i_update_req;
            pend_clr_d = i_clear_req;
            dat1_d     = shadow1_q;
            dat2_d     = shadow2_q;
            step_d     = pend_clr_q ? CLR : L1;
            tmo_err_d  = 1'b0;
            state_d    = S_ISSUE;
          end
        end
        S_ISSUE: begin
          cmd_clr_d = (step_q == CLR);
          cmd_l1_d  = (step_q == L1);
          cmd_l2_d  = (step_q == L2);
          tmo_cnt_d = '0;
          state_d   = S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (!i_command_ready) begin
            cmd_clr_d = 1'b0;
            cmd_l1_d  = 1'b0;
            cmd_l2_d  = 1'b0;
            tmo_cnt_d = '0;
            state_d   = S_WAIT_RDY;
          end else begin
            tmo_cnt_d = tmo_inc;
            timeout   = (tmo_inc >= TIMEOUT_LIMIT);
          end
        end
        S_WAIT_RDY: begin
          if (i_command_ready) begin
            state_d = S_NEXT;
          end else begin
            tmo_cnt_d = tmo_inc;
            timeout   = (tmo_inc >= TIMEOUT_LIMIT);
          end
        end
        S_NEXT: begin
          if ((step_q == CLR && seq_upd_q) || step_q == L1) begin
            step_d  = (step_q == CLR) ? L1 : L2;
            state_d = S_ISSUE;
          end else begin
            seq_upd_d = 1'b0;
            seq_clr_d = 1'b0;
            done_d    = 1'b1;
            state_d   = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (timeout) begin
      tmo_err_d  = 1'b1;
      cmd_clr_d  = 1'b0;
      cmd_l1_d   = 1'b0;
      cmd_l2_d   = 1'b0;
      seq_upd_d  = 1'b0;
      seq_clr_d  = 1'b0;
      pend_upd_d = i_update_req;
      pend_clr_d = i_clear_req;
      state_d    = S_IDLE;
    end

    busy_d = (state_d != S_IDLE) || pend_upd_d || pend_clr_d;
  end

  always_ff @(posedge i_clk_20mhz or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      state_q    <= S_IDLE;
      step_q     <= CLR;
      seq_upd_q  <= 1'b0;
      seq_clr_q  <= 1'b0;
      pend_upd_q <= 1'b0;
      pend_clr_q <= 1'b0;
      shadow1_q  <= BLANK_LINE;
      shadow2_q  <= BLANK_LINE;
      dat1_q     <= BLANK_LINE;
      dat2_q     <= BLANK_LINE;
      cmd_clr_q  <= 1'b0;
      cmd_l1_q   <= 1'b0;
      cmd_l2_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_err_q  <= 1'b0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      seq_upd_q  <= seq_upd_d;
      seq_clr_q  <= seq_clr_d;
      pend_upd_q <= pend_upd_d;
      pend_clr_q <= pend_clr_d;
      shadow1_q  <= shadow1_d;
      shadow2_q  <= shadow2_d;
      dat1_q     <= dat1_d;
      dat2_q     <= dat2_d;
      cmd_clr_q  <= cmd_clr_d;
      cmd_l1_q   <= cmd_l1_d;
      cmd_l2_q   <= cmd_l2_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tmo_err_q  <= tmo_err_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign o_cmd_wr_clear_display = cmd_clr_q;
  assign o_cmd_wr_text_line1    = cmd_l1_q;
  assign o_cmd_wr_text_line2    = cmd_l2_q;
  assign o_dat_ascii_line1      = dat1_q;
  assign o_dat_ascii_line2      = dat2_q;
  assign o_busy                 = busy_q;
  assign o_done                 = done_q;
  assign o_timeout_err          = tmo_err_q;

endmodule

// File: tb/tb_pmod_cls_update_scheduler.sv
// Directed bench for pmod_cls_update_scheduler: a driver-ready model and a command
// monitor run on the falling edge; scenario tasks check their own expectations.
module tb_pmod_cls_update_scheduler;

  localparam logic [127:0] BLANK = {16{8'h20}};

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         ce;
  logic         upd = 1'b0;
  logic         clr = 1'b0;
  logic [127:0] line1 = '0;
  logic [127:0] line2 = '0;
  logic         ready;
  logic         cmd_clr, cmd_l1, cmd_l2;
  logic [127:0] dat1, dat2;
  logic         busy, done, tmo_err;

  int           ready_mode = 0;
  int           vec_cnt = 0;
  int           err_cnt = 0;

  // Monitor / model state, written only by the falling-edge process.
  int           ce_div = 0;
  int           drop = 0;
  int           cmd_cnt = 0;
  int           done_cnt = 0;
  int           onehot_err = 0;
  int           hold_err = 0;
  int           stab_err = 0;
  int           cmd_log [0:63];
  logic [127:0] log_d1 [0:63];
  logic [127:0] log_d2 [0:63];
  logic [2:0]   cmd_prev = 3'b000;
  logic [127:0] last_d1 = '0;
  logic [127:0] last_d2 = '0;

  pmod_cls_update_scheduler #(.parm_fast_simulation(1)) dut (
    .i_clk_20mhz           (clk),
    .i_rstn_20mhz          (rstn),
    .i_ce_2_5mhz           (ce),
    .i_update_req          (upd),
    .i_clear_req           (clr),
    .i_line1               (line1),
    .i_line2               (line2),
    .i_command_ready       (ready),
    .o_cmd_wr_clear_display(cmd_clr),
    .o_cmd_wr_text_line1   (cmd_l1),
    .o_cmd_wr_text_line2   (cmd_l2),
    .o_dat_ascii_line1     (dat1),
    .o_dat_ascii_line2     (dat2),
    .o_busy                (busy),
    .o_done                (done),
    .o_timeout_err         (tmo_err)
  );

  always #25 clk = ~clk;

  // Command monitor, ready model (drops 3 ce ticks per command) and ce divider.
  always @(negedge clk) begin
    logic [2:0] cmd_now;
    cmd_now = {cmd_l2, cmd_l1, cmd_clr};
    if ($countones(cmd_now) > 1) onehot_err++;
    for (int b = 0; b < 3; b++) begin
      if (cmd_now[b] && !cmd_prev[b]) begin
        if (cmd_cnt < 64) begin
          cmd_log[cmd_cnt] = b;
          log_d1[cmd_cnt]  = dat1;
          log_d2[cmd_cnt]  = dat2;
        end
        cmd_cnt++;
        last_d1 = dat1;
        last_d2 = dat2;
      end
      if (!cmd_now[b] && cmd_prev[b] && rstn && !tmo_err && ready !== 1'b0) hold_err++;
    end
    if ((cmd_now[1] || cmd_now[2]) && (dat1 !== last_d1 || dat2 !== last_d2)) stab_err++;
    if (done === 1'b1) done_cnt++;
    cmd_prev = cmd_now;

    if (ready_mode == 1) begin
      ready = 1'b1;
      drop  = 0;
    end else if (ready_mode == 2) begin
      ready = 1'b0;
      drop  = 0;
    end else if (drop > 0) begin
      if (ce === 1'b1) drop--;
      if (drop == 0) ready = 1'b1;
    end else begin
      ready = 1'b1;
      if (cmd_now != 3'b000) begin
        ready = 1'b0;
        drop  = 3;
      end
    end

    ce_div = (ce_div + 1) % 8;
    ce     = (ce_div == 7);
  end

  task automatic step_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ce(input int n);
    repeat (n) begin
      do @(posedge clk); while (ce !== 1'b1);
    end
    #1;
  endtask

  task automatic pulse(input logic u, input logic c, input logic [127:0] l1, input logic [127:0] l2);
    @(negedge clk);
    line1 = l1;
    line2 = l2;
    upd   = u;
    clr   = c;
    @(negedge clk);
    upd = 1'b0;
    clr = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step_clk(1);
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cmd_l1(input logic level, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step_clk(1);
      if (cmd_l1 === level) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    step_clk(3);
    vec_cnt++; if ({cmd_clr, cmd_l1, cmd_l2} !== 3'b000) begin err_cnt++; $display("[TB] FAIL reset_cmds: got %b expected 000", {cmd_clr, cmd_l1, cmd_l2}); end
    vec_cnt++; if (dat1 !== BLANK || dat2 !== BLANK) begin err_cnt++; $display("[TB] FAIL reset_data: got %h/%h expected %h", dat1, dat2, BLANK); end
    vec_cnt++; if ({busy, done, tmo_err} !== 3'b000) begin err_cnt++; $display("[TB] FAIL reset_flags: got busy/done/err=%b expected 000", {busy, done, tmo_err}); end
    @(negedge clk);
    rstn = 1'b1;
    step_clk(10);
    vec_cnt++; if ({busy, cmd_clr, cmd_l1, cmd_l2} !== 4'b0000) begin err_cnt++; $display("[TB] FAIL reset_release_idle: got busy/cmds=%b expected 0000", {busy, cmd_clr, cmd_l1, cmd_l2}); end
  endtask

  task automatic test_update_only;
    logic [127:0] a, b;
    int c0, d0;
    bit ok;
    a = "HELLO, PMOD CLS!";
    b = "WORLD 0123456789";
    c0 = cmd_cnt; d0 = done_cnt;
    pulse(1'b1, 1'b0, a, b);
    wait_done(d0 + 1, 3000, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("[TB] FAIL upd_done_seen: got none expected 1 o_done"); end
    step_clk(40);
    vec_cnt++; if (cmd_cnt - c0 != 2) begin err_cnt++; $display("[TB] FAIL upd_cmd_count: got %0d expected 2", cmd_cnt - c0); end
    vec_cnt++; if (cmd_log[c0] != 1 || cmd_log[c0 + 1] != 2) begin err_cnt++; $display("[TB] FAIL upd_order: got %0d,%0d expected 1,2", cmd_log[c0], cmd_log[c0 + 1]); end
    vec_cnt++; if (log_d1[c0] !== a || log_d2[c0 + 1] !== b) begin err_cnt++; $display("[TB] FAIL upd_text: got %h/%h expected %h/%h", log_d1[c0], log_d2[c0 + 1], a, b); end
    vec_cnt++; if (dat1 !== a || dat2 !== b) begin err_cnt++; $display("[TB] FAIL upd_text_after: got %h/%h expected %h/%h", dat1, dat2, a, b); end
    vec_cnt++; if (done_cnt - d0 != 1) begin err_cnt++; $display("[TB] FAIL upd_done_count: got %0d expected 1", done_cnt - d0); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("[TB] FAIL upd_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_clear_update;
    int c0, d0, h0;
    bit ok;
    c0 = cmd_cnt; d0 = done_cnt; h0 = hold_err;
    pulse(1'b1, 1'b1, "CLEAR THEN LINE1", "CLEAR THEN LINE2");
    wait_done(d0 + 1, 4000, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("[TB] FAIL both_done_seen: got none expected 1 o_done"); end
    step_clk(40);
    vec_cnt++; if (cmd_cnt - c0 != 3) begin err_cnt++; $display("[TB] FAIL both_cmd_count: got %0d expected 3", cmd_cnt - c0); end
    vec_cnt++; if (cmd_log[c0] != 0 || cmd_log[c0 + 1] != 1 || cmd_log[c0 + 2] != 2) begin err_cnt++; $display("[TB] FAIL both_order: got %0d,%0d,%0d expected 0,1,2", cmd_log[c0], cmd_log[c0 + 1], cmd_log[c0 + 2]); end
    vec_cnt++; if (hold_err != h0) begin err_cnt++; $display("[TB] FAIL both_hold: got %0d early drops expected 0", hold_err - h0); end
    vec_cnt++; if (done_cnt - d0 != 1) begin err_cnt++; $display("[TB] FAIL both_done_count: got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] f1, f2, n1, n2;
    int c0, d0;
    bit ok;
    f1 = "FIRST TEXT LINE1"; f2 = "FIRST TEXT LINE2";
    n1 = "ABC NEW LINE ONE"; n2 = "ABC NEW LINE TWO";
    c0 = cmd_cnt; d0 = done_cnt;
    pulse(1'b1, 1'b0, f1, f2);
    wait_cmd_l1(1'b1, 1000, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("[TB] FAIL b2b_l1_seen: got no L1 expected L1 command"); end
    pulse(1'b1, 1'b0, n1, n2);
    wait_done(d0 + 2, 6000, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("[TB] FAIL b2b_done_seen: got %0d expected 2 o_done", done_cnt - d0); end
    step_clk(60);
    vec_cnt++; if (cmd_cnt - c0 != 4) begin err_cnt++; $display("[TB] FAIL b2b_cmd_count: got %0d expected 4", cmd_cnt - c0); end
    vec_cnt++; if (cmd_log[c0] != 1 || cmd_log[c0 + 1] != 2 || cmd_log[c0 + 2] != 1 || cmd_log[c0 + 3] != 2) begin err_cnt++; $display("[TB] FAIL b2b_order: got %0d,%0d,%0d,%0d expected 1,2,1,2", cmd_log[c0], cmd_log[c0 + 1], cmd_log[c0 + 2], cmd_log[c0 + 3]); end
    vec_cnt++; if (log_d1[c0] !== f1 || log_d2[c0 + 1] !== f2) begin err_cnt++; $display("[TB] FAIL b2b_old_text: got %h/%h expected %h/%h", log_d1[c0], log_d2[c0 + 1], f1, f2); end
    vec_cnt++; if (log_d1[c0 + 2] !== n1 || log_d2[c0 + 3] !== n2) begin err_cnt++; $display("[TB] FAIL b2b_new_text: got %h/%h expected %h/%h", log_d1[c0 + 2], log_d2[c0 + 3], n1, n2); end
    vec_cnt++; if (done_cnt - d0 != 2) begin err_cnt++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); end
  endtask

  task automatic test_timeout;
    int d0;
    bit ok;
    ready_mode = 1;
    d0 = done_cnt;
    pulse(1'b1, 1'b0, "TIMEOUT LINE ONE", "TIMEOUT LINE TWO");
    wait_cmd_l1(1'b1, 1000, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("[TB] FAIL tmo_l1_seen: got no L1 expected L1 command"); end
    wait_ce(990);
    vec_cnt++; if ({tmo_err, cmd_l1} !== 2'b01) begin err_cnt++; $display("[TB] FAIL tmo_before_limit: got err/l1=%b expected 01", {tmo_err, cmd_l1}); end
    wait_ce(20);
    vec_cnt++; if (tmo_err !== 1'b1) begin err_cnt++; $display("[TB] FAIL tmo_flag: got %b expected 1", tmo_err); end
    vec_cnt++; if ({cmd_clr, cmd_l1, cmd_l2, busy} !== 4'b0000) begin err_cnt++; $display("[TB] FAIL tmo_idle: got cmds/busy=%b expected 0000", {cmd_clr, cmd_l1, cmd_l2, busy}); end
    vec_cnt++; if (done_cnt != d0) begin err_cnt++; $display("[TB] FAIL tmo_no_done: got %0d pulses expected 0", done_cnt - d0); end
    ready_mode = 0;
    pulse(1'b1, 1'b0, "RECOVERED LINE 1", "RECOVERED LINE 2");
    wait_ce(3);
    vec_cnt++; if (tmo_err !== 1'b0) begin err_cnt++; $display("[TB] FAIL tmo_cleared: got %b expected 0", tmo_err); end
    wait_done(d0 + 1, 3000, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("[TB] FAIL tmo_recover_done: got none expected 1 o_done"); end
    step_clk(40);
  endtask

  task automatic test_reset_mid;
    int c1, d0;
    bit ok;
    d0 = done_cnt;
    pulse(1'b1, 1'b0, "RESET TEST TEXT1", "RESET TEST TEXT2");
    wait_cmd_l1(1'b1, 1000, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("[TB] FAIL rst_l1_seen: got no L1 expected L1 command"); end
    wait_cmd_l1(1'b0, 1000, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("[TB] FAIL rst_l1_release: got L1 stuck expected drop"); end
    step_clk(2);
    rstn = 1'b0;
    #1;
    vec_cnt++; if ({cmd_clr, cmd_l1, cmd_l2, busy, done, tmo_err} !== 6'b000000) begin err_cnt++; $display("[TB] FAIL rst_mid_flags: got %b expected 000000", {cmd_clr, cmd_l1, cmd_l2, busy, done, tmo_err}); end
    vec_cnt++; if (dat1 !== BLANK || dat2 !== BLANK) begin err_cnt++; $display("[TB] FAIL rst_mid_data: got %h/%h expected %h", dat1, dat2, BLANK); end
    c1 = cmd_cnt;
    step_clk(4);
    @(negedge clk);
    rstn = 1'b1;
    step_clk(200);
    vec_cnt++; if (cmd_cnt != c1 || busy !== 1'b0) begin err_cnt++; $display("[TB] FAIL rst_mid_quiet: got %0d cmds busy=%b expected 0 cmds busy=0", cmd_cnt - c1, busy); end
    vec_cnt++; if (done_cnt != d0) begin err_cnt++; $display("[TB] FAIL rst_mid_no_done: got %0d pulses expected 0", done_cnt - d0); end
  endtask

  task automatic test_idle_ready_low;
    int c0, d0;
    bit ok;
    c0 = cmd_cnt; d0 = done_cnt;
    ready_mode = 2;
    step_clk(2);
    pulse(1'b1, 1'b0, "WAITING FOR RDY1", "WAITING FOR RDY2");
    wait_ce(5);
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("[TB] FAIL rdylow_busy: got %b expected 1", busy); end
    vec_cnt++; if ({cmd_clr, cmd_l1, cmd_l2} !== 3'b000 || cmd_cnt != c0) begin err_cnt++; $display("[TB] FAIL rdylow_no_cmd: got %b (%0d issued) expected 000", {cmd_clr, cmd_l1, cmd_l2}, cmd_cnt - c0); end
    ready_mode = 0;
    wait_done(d0 + 1, 3000, ok);
    vec_cnt++; if (!ok) begin err_cnt++; $display("[TB] FAIL rdylow_done: got none expected 1 o_done"); end
    step_clk(40);
    vec_cnt++; if (cmd_cnt - c0 != 2) begin err_cnt++; $display("[TB] FAIL rdylow_cmd_count: got %0d expected 2", cmd_cnt - c0); end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_update_only();
    test_clear_update();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_idle_ready_low();
    vec_cnt++; if (onehot_err != 0) begin err_cnt++; $display("[TB] FAIL cmd_onehot: got %0d overlaps expected 0", onehot_err); end
    vec_cnt++; if (stab_err != 0) begin err_cnt++; $display("[TB] FAIL data_stable: got %0d changes expected 0", stab_err); end
    vec_cnt++; if (hold_err != 0) begin err_cnt++; $display("[TB] FAIL cmd_hold: got %0d early drops expected 0", hold_err); end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pmod_cls_update_scheduler.md
PMOD_CLS_UPDATE_SCHEDULER -- requirements
Module: pmod_cls_update_scheduler

Interface
REQ-001 SHALL have parameter parm_fast_simulation, default 0: when nonzero, the timeout limit is 1000 ce ticks.
REQ-002 SHALL have parameter parm_timeout_ce, default 2500000: the timeout limit in ce ticks (1 s at 2.5 MHz), used when parm_fast_simulation=0.
REQ-003 SHALL have port i_clk_20mhz, in, 1: the single clock. Reset is asynchronous and active-low.
REQ-004 SHALL have port i_rstn_20mhz, in, 1: asynchronous active-low reset.
REQ-005 SHALL have port i_ce_2_5mhz, in, 1: clock enable, 4x the SPI rate.
REQ-006 SHALL have port i_update_req, in, 1: single-clock pulse requesting a rewrite of both text lines.
REQ-007 SHALL have port i_clear_req, in, 1: single-clock pulse requesting a display clear.
REQ-008 SHALL have ports i_line1 and i_line2, in, t_pmod_cls_ascii_line_16 (128 bits each): text, captured on i_update_req.
REQ-009 SHALL have port i_command_ready, in, 1: the ready flag from the CLS driver.
REQ-010 SHALL have ports o_cmd_wr_clear_display, o_cmd_wr_text_line1 and o_cmd_wr_text_line2, out, 1 each: commands to the driver.
REQ-011 SHALL have ports o_dat_ascii_line1 and o_dat_ascii_line2, out, 128 each: text to the driver.
REQ-012 SHALL have port o_busy, out, 1: a sequence is in progress or a request is pending.
REQ-013 SHALL have port o_done, out, 1: one-clock pulse when a sequence completes.
REQ-014 SHALL have port o_timeout_err, out, 1: sticky driver-timeout flag.

Function
REQ-015 SHALL sample i_update_req and i_clear_req on every clock, not ce-gated, into the pending flags pend_upd and pend_clr.
REQ-016 SHALL load i_line1/i_line2 into the shadow registers on each i_update_req; a later request overwrites the earlier one (last writer wins).
REQ-017 SHALL use FSM states S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_RDY and S_NEXT, and SHALL use a step register with values CLR, L1, L2.
REQ-018 SHALL advance the FSM only on clocks where i_ce_2_5mhz=1.
REQ-019 S_IDLE: when any pending flag is set and i_command_ready=1, the block SHALL:
  - snapshot the pending flags into the sequence flags;
  - clear the pending flags;
  - copy the shadow registers to o_dat_ascii_line1/2;
  - set the step to CLR if pend_clr is set, else L1;
  - go to S_ISSUE.
REQ-020 S_ISSUE SHALL assert exactly one command matching the step, then go to S_WAIT_ACK.
REQ-021 S_WAIT_ACK SHALL hold that command until i_command_ready=0 is seen, then deassert it and go to S_WAIT_RDY.
REQ-022 S_WAIT_RDY SHALL wait for i_command_ready=1, then go to S_NEXT.
REQ-023 S_NEXT SHALL apply these transitions:
  - from CLR: to L1 (via S_ISSUE) if the update flag is in the sequence, else finish;
  - from L1: to L2 (via S_ISSUE);
  - from L2: finish.
REQ-024 On finish, the block SHALL pulse o_done for one clock and return to S_IDLE.
REQ-025 Sequences SHALL be: clear-only = CLR; update-only = L1, L2; both requests (same cycle or both pending) = CLR, L1, L2.
REQ-026 Requests arriving during a sequence SHALL set the pending flags only; they start a new sequence after the current one completes.
REQ-027 o_dat_ascii_line1/2 SHALL be stable from S_ISSUE of L1 through the finish of the sequence.
REQ-028 At most one o_cmd_* output SHALL be high at any time.
REQ-029 The timeout counter SHALL:
  - be 23 bits;
  - clear on entry to S_WAIT_ACK and to S_WAIT_RDY;
  - increment on each ce tick in those states;
  - saturate and never wrap.
REQ-030 When the timeout counter reaches the limit, the block SHALL:
  - set o_timeout_err;
  - deassert all commands;
  - clear the sequence flags and the pending flags;
  - return to S_IDLE without pulsing o_done.
REQ-031 o_timeout_err SHALL clear when the next sequence starts in S_IDLE.
REQ-032 o_busy SHALL equal (state != S_IDLE) OR pend_upd OR pend_clr.

Reset
REQ-033 On i_rstn_20mhz=0, the block SHALL asynchronously set:
  - the state to S_IDLE and the step to CLR;
  - all o_cmd_* outputs to 0;
  - o_dat_ascii_line1/2 and the shadow registers to 128'h20 repeated (16 ASCII spaces);
  - o_busy, o_done and o_timeout_err to 0;
  - the pending flags and the timeout counter to 0.
REQ-034 Reset asserted mid-sequence SHALL abort immediately with no o_done, and SHALL deassert commands in the same clock it is asserted.
REQ-035 Reset release SHALL be synchronized internally with a two-flop deassertion synchronizer.

Verification
REQ-036 Update-only: line1="HELLO...", line2="WORLD...", ready model drops for 3 ce ticks after each command → sequence L1 then L2, data stable throughout, one o_done, no clear command.
REQ-037 Clear and update asserted in the same clock → commands issued in the order CLR, L1, L2, each command held until ready falls, and o_done pulses exactly once.
REQ-038 Second update request during L1 with new text "ABC..." → first sequence completes with the old text, then a second L1/L2 sequence runs with "ABC...", giving 2 o_done pulses in total.
REQ-039 parm_fast_simulation=1, ready held at 1 after the command is asserted → after 1000 ce ticks in S_WAIT_ACK: o_timeout_err=1, all commands 0, S_IDLE, no o_done; the next request clears o_timeout_err.
REQ-040 Reset pulsed low during S_WAIT_RDY of L1 → all outputs return to their reset values at once, and no command is issued after release until a new request arrives.
REQ-041 A request while i_command_ready=0 in S_IDLE → o_busy=1 and no command is asserted until ready rises.
